// File: rtl/fp_mul_share_arbiter.sv
// fp_mul_share_arbiter: round-robin sharing of one fixed-latency pipelined multiplier among N_REQ requesters.
// A tag pipeline that shadows the multiplier routes each product back to the requester that issued it.
module fp_mul_share_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int LAT    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       mul_a,
  output logic [DATA_W-1:0]       mul_b,
  input  logic [DATA_W-1:0]       mul_result,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] j;
  logic          found;
  logic          accept;
  logic [LAT:0]  tag_v;
  logic [IW-1:0] tag_idx [LAT+1];
  // Scan from ptr upward with wrap; the first requesting index wins.
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    found     = 1'b0;
    j         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = IW'((int'(ptr) + k) % N_REQ);
      if (!found && req_valid[j]) begin
        found        = 1'b1;
        req_ready[j] = 1'b1;
        gnt_idx      = j;
      end
    end
  end
  assign accept = found;
  assign busy   = (|tag_v) | (|rsp_valid);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      tag_v     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      for (int s = 0; s <= LAT; s++) tag_idx[s] <= '0;
    end else begin
      tag_v      <= {tag_v[LAT-1:0], accept};
      tag_idx[0] <= gnt_idx;
      for (int s = 1; s <= LAT; s++) tag_idx[s] <= tag_idx[s-1];
      // The last tag stage lines up with the multiplier output, so it alone decides the response.
      rsp_valid  <= tag_v[LAT] ? N_REQ'(1) << tag_idx[LAT] : '0;
      rsp_data   <= tag_v[LAT] ? mul_result : rsp_data;
      mul_a      <= accept ? req_a[gnt_idx*DATA_W +: DATA_W] : mul_a;
      mul_b      <= accept ? req_b[gnt_idx*DATA_W +: DATA_W] : mul_b;
      ptr        <= !accept ? ptr : (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_fp_mul_share_arbiter.sv
// tb_fp_mul_share_arbiter: directed checks of grant order, response routing, reset and fairness.
// The shared multiplier is an ideal 5-cycle delay line around a truncating float multiply.
module tb_fp_mul_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 5;
  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   mul_a, mul_b, mul_result, rsp_data;
  logic [N-1:0]   rsp_valid;
  logic           busy;
  logic [W-1:0]   d [L];
  logic [W-1:0]   prod [N];
  int checks = 0;
  int errors = 0;
  fp_mul_share_arbiter #(.N_REQ(N), .DATA_W(W), .LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [8:0]  e;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {1'b0, a[30:23]} + {1'b0, b[30:23]} - 9'd127;
    return p[47] ? {a[31] ^ b[31], e[7:0] + 8'd1, p[46:24]} : {a[31] ^ b[31], e[7:0], p[45:23]};
  endfunction
  always_ff @(posedge clk) begin
    d[0] <= fmul(mul_a, mul_b);
    for (int s = 1; s < L; s++) d[s] <= d[s-1];
  end
  assign mul_result = d[L-1];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    prod[0] = 32'h40000000;
    prod[1] = 32'h40400000;
    prod[2] = 32'h40800000;
    prod[3] = 32'h40C00000;
    // asynchronous reset applied mid-cycle
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    tick();
    rst_n = 1'b1;
    // single issue from requester 1: 2.0 * 3.0
    req_valid = 4'b0010;
    req_a = {32'h0, 32'h0, 32'h40000000, 32'h0};
    req_b = {32'h0, 32'h0, 32'h40400000, 32'h0};
    #1;
    chk("single_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    chk("single_mul_a", mul_a, 32'h40000000);
    chk("single_mul_b", mul_b, 32'h40400000);
    chk("single_busy", 32'(busy), 1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("single_early", 32'(rsp_valid), 0);
    end
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), 32'b0010);
    chk("single_rsp_data", rsp_data, 32'h40C00000);
    tick();
    chk("single_pulse_end", 32'(rsp_valid), 0);
    chk("single_data_hold", rsp_data, 32'h40C00000);
    chk("single_idle", 32'(busy), 0);
    // saturation: all four requesters continuously valid
    do_reset();
    req_a = {4{32'h40000000}};
    req_b = {32'h40400000, 32'h40000000, 32'h3FC00000, 32'h3F800000};
    for (int c = 0; c <= 18; c++) begin
      if (c >= 1 && c <= 6) chk("sat_no_rsp", 32'(rsp_valid), 0);
      if (c >= 7) begin
        chk("sat_rsp_valid", 32'(rsp_valid), 32'(1) << ((c - 7) % N));
        chk("sat_rsp_data", rsp_data, prod[(c - 7) % N]);
      end
      req_valid = c < 12 ? 4'b1111 : 4'b0000;
      #1;
      chk("sat_ready", 32'(req_ready), c < 12 ? 32'(1) << (c % N) : 0);
      tick();
    end
    // wrap priority: grant 1 leaves ptr at 2, then 3 beats 0
    req_valid = 4'b0010;
    #1;
    chk("wrap_first", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1001;
    #1;
    chk("wrap_grant3", 32'(req_ready), 32'b1000);
    tick();
    chk("wrap_grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    // fairness: requester 0 always valid, requester 2 joins at cycle 3
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req_valid = c >= 3 ? 4'b0101 : 4'b0001;
      #1;
      chk("fair_ready", 32'(req_ready), c == 3 ? 32'b0100 : 32'b0001);
      tick();
    end
    req_valid = '0;
    // reset with three products in flight
    do_reset();
    req_valid = 4'b0111;
    tick();
    tick();
    tick();
    req_valid = '0;
    chk("flight_busy", 32'(busy), 1);
    do_reset();
    chk("flight_cleared", 32'(busy), 0);
    for (int c = 0; c < 10; c++) begin
      chk("flight_no_rsp", 32'(rsp_valid), 0);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
